mem_tg2_run_monitor: RTL and testbench
======================================

# mem_tg2_run_monitor

Per-channel run monitor for the AXI-Mem traffic generator. It sits between the TG2 cores and the TG CSR block. It watches each channel's active flag from the CSR block and the raw completion/failure indications from the TG2 core, then produces the registered pass/fail/timeout levels and the 64-bit per-run clock counts that the CSR block latches and exposes to the host.

## Interface
Parameters:
- NUM_TG, 4: number of traffic-generator channels.
- TIMEOUT_W, 32: width of the watchdog threshold.

Ports:
- clk  input  1  CSR/TG clock; the single clock of the block.
- rst_n  input  1  reset, asynchronous, active-low.
- mem_tg_active  input  NUM_TG  per-channel run flag from the CSR block; a rising edge starts a run.
- tg_test_complete  input  NUM_TG  TG2 core completion level.
- tg_test_failed  input  NUM_TG  TG2 core failure level.
- timeout_cycles  input  TIMEOUT_W  watchdog threshold in clocks; 0 disables the watchdog. Shared by all channels.
- tg_pass  output  NUM_TG  registered pass level.
- tg_fail  output  NUM_TG  registered fail level.
- tg_timeout  output  NUM_TG  registered timeout level.
- clock_count  output  64 x NUM_TG (unpacked [NUM_TG])  clocks elapsed in the current or last run.

## Operation
- Each channel runs an independent FSM with states IDLE, RUN, PASS, FAIL, TIMEOUT.
- Edge detection:
  - act_re = active & ~active_q.
  - cmp_re and fail_re are rising edges of the core levels, computed from registered copies.
  - Stale levels left over from a previous run are therefore ignored.
- IDLE: all outputs low. On act_re go to RUN and load clock_count to 0.
- RUN:
  - clock_count increments by 1 each cycle and saturates at 64'hFFFF_FFFF_FFFF_FFFF.
  - Transition priority within one cycle:
    - fail_re → FAIL, whether or not cmp_re is also set;
    - cmp_re with tg_test_failed low → PASS;
    - cmp_re with tg_test_failed high → FAIL;
    - watchdog hit → TIMEOUT;
    - active low → IDLE (abort; clock_count frozen, no status asserted).
- PASS / FAIL / TIMEOUT:
  - The matching output is held high and clock_count is frozen.
  - The FSM stays in this state until the next act_re, which clears all three outputs, zeroes the count and enters RUN.
  - The low cycle this produces lets the CSR block detect a fresh rising edge on the next result.
- act_re in any state restarts the run (RUN entry) and takes priority over every other event.
- The watchdog hit condition is timeout_cycles != 0 and clock_count[TIMEOUT_W-1:0] + 1 == timeout_cycles with clock_count upper bits zero. Comparison uses the lower TIMEOUT_W bits only while the count fits in TIMEOUT_W bits.
- Channels never interact. Simultaneous events on different channels are handled independently.

## Timing
- Reset values: all outputs 0, clock_count 0 for every channel, all FSMs in IDLE, edge registers 0.
- Reset asserted mid-run returns the channel to IDLE immediately (async). Outputs drop without any status being reported.
- act_re sampled at edge N: state is RUN and clock_count = 0 after edge N; clock_count = 1 after edge N+1.
- Core edge visible at edge N (cmp_re computed from level at N and level at N-1): tg_pass/tg_fail is high after edge N.
  - Latency is 1 clock from the first cycle the raw level is sampled high.
- Watchdog: with timeout_cycles = T, tg_timeout rises after edge N+T, where N is the start edge. The final clock_count = T.
- clock_count is registered and stable while the channel is not in RUN.

## Configuration
- MEM_TG2_WATCHDOG_EN defined: watchdog logic and the TIMEOUT state are present, as described above.
- MEM_TG2_WATCHDOG_EN undefined:
  - TIMEOUT state and comparator are removed and timeout_cycles is ignored.
  - tg_timeout is tied to 0.
  - A run ends only on a core result or an abort.

## Structure
- tg2_csr_pkg receives:
  - the typedef t_tg_run_state (enum IDLE/RUN/PASS/FAIL/TIMEOUT, 3 bits);
  - the localparam TG_CLK_CNT_W = 64;
  - the saturation constant TG_CLK_CNT_MAX.
- One sub-module, mem_tg2_run_ch, implements a single channel's FSM, edge registers, counter and watchdog. The top level is a generate loop over NUM_TG instances plus port vectorization.

## Test plan
- Basic pass: active rises at cycle 10, tg_test_complete rises at cycle 110 with failed=0 → tg_pass=1 after the next edge; clock_count = 100 and then frozen.
- Fail priority: test_complete and test_failed rise in the same cycle → tg_fail=1, tg_pass stays 0.
- Watchdog (macro defined): timeout_cycles=50, no completion → tg_timeout=1 exactly 50 clocks after start, clock_count=50. Same stimulus with timeout_cycles=0 → channel stays in RUN.
- Restart and stale levels: pass asserted with complete held high, then active re-rises → tg_pass drops 1 cycle after the start edge, count restarts at 0, and no new pass is reported until complete toggles low→high.
- Abort and reset: active drops at count 20 → outputs stay 0 and count holds 20. rst_n asserted mid-run on channel 1 while channel 0 passes → all outputs and counts read 0 after reset.
- Macro undefined: timeout_cycles=5, no completion for 100 clocks → tg_timeout stays 0 and clock_count = 100.

Source files
------------

// File: rtl/mem_tg2_run_monitor_pkg.sv
// -----------------------------------------------------------------------------
// tg2_csr_pkg
// Shared types and constants for the TG2 run monitor and the TG CSR block.
//   t_tg_run_state : per-channel run FSM encoding
//   TG_CLK_CNT_W   : width of the per-run clock counter
//   TG_CLK_CNT_MAX : saturation value of the per-run clock counter
// -----------------------------------------------------------------------------
package tg2_csr_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN     = 3'd1,
      PASS    = 3'd2,
      FAIL    = 3'd3,
      TIMEOUT = 3'd4
   } t_tg_run_state;

   localparam int TG_CLK_CNT_W = 64;
   localparam logic [TG_CLK_CNT_W-1:0] TG_CLK_CNT_MAX = {TG_CLK_CNT_W{1'b1}};

   function automatic logic [TG_CLK_CNT_W-1:0] cnt_sat_inc(input logic [TG_CLK_CNT_W-1:0] cnt);
      return (cnt == TG_CLK_CNT_MAX) ? cnt : cnt + {{(TG_CLK_CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/mem_tg2_run_monitor_if.sv
// -----------------------------------------------------------------------------
// mem_tg2_run_monitor_if
// Bundle between the CSR block / TG2 cores and the run monitor.
//   mem_tg_active    : per-channel run flag (rising edge starts a run)
//   tg_test_complete : core completion level
//   tg_test_failed   : core failure level
//   timeout_cycles   : shared watchdog threshold, 0 disables
//   tg_pass/fail/timeout : registered result levels
//   clock_count      : per-channel clocks of the current or last run
// slave  : the monitor side; master : the CSR/core side.
// -----------------------------------------------------------------------------
interface mem_tg2_run_monitor_if
   import tg2_csr_pkg::*;
#(
   parameter int NUM_TG    = 4,
   parameter int TIMEOUT_W = 32
);
   logic [NUM_TG-1:0]       mem_tg_active;
   logic [NUM_TG-1:0]       tg_test_complete;
   logic [NUM_TG-1:0]       tg_test_failed;
   logic [TIMEOUT_W-1:0]    timeout_cycles;
   logic [NUM_TG-1:0]       tg_pass;
   logic [NUM_TG-1:0]       tg_fail;
   logic [NUM_TG-1:0]       tg_timeout;
   logic [TG_CLK_CNT_W-1:0] clock_count [NUM_TG];

   modport slave (
      input  mem_tg_active, tg_test_complete, tg_test_failed, timeout_cycles,
      output tg_pass, tg_fail, tg_timeout, clock_count
   );

   modport master (
      output mem_tg_active, tg_test_complete, tg_test_failed, timeout_cycles,
      input  tg_pass, tg_fail, tg_timeout, clock_count
   );
endinterface

// File: rtl/mem_tg2_run_monitor_ch.sv
// -----------------------------------------------------------------------------
// mem_tg2_run_ch
// One channel of the run monitor: edge registers, run FSM, saturating clock
// counter and watchdog.
// Ports: clk, rst_n (async, active-low); active / test_complete / test_failed
// levels; timeout_cycles threshold; registered pass / fail / timeout levels and
// clock_count.
// Build option: MEM_TG2_WATCHDOG_EN enables the watchdog and TIMEOUT state;
// without it timeout_cycles is ignored and timeout stays 0.
//
// state   | meaning
// IDLE    | no run, never started or aborted; outputs low
// RUN     | run in progress, clock_count incrementing
// PASS    | core reported completion without failure; pass held
// FAIL    | core reported failure; fail held
// TIMEOUT | watchdog threshold reached; timeout held
// -----------------------------------------------------------------------------
module mem_tg2_run_ch
   import tg2_csr_pkg::*;
#(
   parameter int TIMEOUT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    active,
   input  logic                    test_complete,
   input  logic                    test_failed,
   input  logic [TIMEOUT_W-1:0]    timeout_cycles,
   output logic                    pass,
   output logic                    fail,
   output logic                    timeout,
   output logic [TG_CLK_CNT_W-1:0] clock_count
);

   t_tg_run_state           state, state_nxt;
   logic [TG_CLK_CNT_W-1:0] cnt_nxt;
   logic [TG_CLK_CNT_W-1:0] cnt_inc;
   logic                    active_q, cmp_q, fail_q;
   logic                    act_re, cmp_re, fail_re;
   logic                    wd_hit;

   // Edges are taken against the previous sample so a level left high from an
   // earlier run cannot end a new one.
   assign act_re  = active & ~active_q;
   assign cmp_re  = test_complete & ~cmp_q;
   assign fail_re = test_failed & ~fail_q;
   assign cnt_inc = cnt_sat_inc(clock_count);

`ifdef MEM_TG2_WATCHDOG_EN
   logic [TIMEOUT_W-1:0] cnt_lo_inc;
   logic                 cnt_fits;

   // Only meaningful while the count still fits in the threshold width.
   assign cnt_lo_inc = clock_count[TIMEOUT_W-1:0] + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
   assign cnt_fits   = (clock_count >> TIMEOUT_W) == '0;
   assign wd_hit     = (timeout_cycles != '0) && cnt_fits && (cnt_lo_inc == timeout_cycles);
`else
   logic unused_timeout_cycles;

   assign unused_timeout_cycles = ^timeout_cycles;
   assign wd_hit                = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = clock_count;
      if (act_re) begin
         state_nxt = RUN;
         cnt_nxt   = '0;
      end else begin
         case (state)
            RUN: begin
               if (fail_re) begin
                  state_nxt = FAIL;
                  cnt_nxt   = cnt_inc;
               end else if (cmp_re) begin
                  state_nxt = test_failed ? FAIL : PASS;
                  cnt_nxt   = cnt_inc;
               end else if (wd_hit) begin
                  state_nxt = TIMEOUT;
                  cnt_nxt   = cnt_inc;
               end else if (!active) begin
                  // abort: count frozen at its last running value
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         clock_count <= '0;
         active_q    <= 1'b0;
         cmp_q       <= 1'b0;
         fail_q      <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_nxt;
         clock_count <= cnt_nxt;
         active_q    <= active;
         cmp_q       <= test_complete;
         fail_q      <= test_failed;
         pass        <= (state_nxt == PASS);
         fail        <= (state_nxt == FAIL);
         timeout     <= (state_nxt == TIMEOUT);
      end
   end

endmodule

// File: rtl/mem_tg2_run_monitor.sv
// -----------------------------------------------------------------------------
// mem_tg2_run_monitor
// Per-channel run monitor between the TG2 cores and the TG CSR block.
// Ports: clk, rst_n (async, active-low); bus (mem_tg2_run_monitor_if.slave)
// carrying the active/complete/failed levels, the shared timeout threshold and
// the pass/fail/timeout levels plus per-channel clock counts.
// Build option: MEM_TG2_WATCHDOG_EN enables the per-channel watchdog.
// Channels are fully independent instances of mem_tg2_run_ch.
// -----------------------------------------------------------------------------
module mem_tg2_run_monitor
   import tg2_csr_pkg::*;
#(
   parameter int NUM_TG    = 4,
   parameter int TIMEOUT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mem_tg2_run_monitor_if.slave bus
);

   logic [NUM_TG-1:0]       pass_v, fail_v, timeout_v;
   logic [TG_CLK_CNT_W-1:0] cnt_v [NUM_TG];

   for (genvar gi = 0; gi < NUM_TG; gi++) begin : g_ch
      mem_tg2_run_ch #(
         .TIMEOUT_W (TIMEOUT_W)
      ) u_ch (
         .clk            (clk),
         .rst_n          (rst_n),
         .active         (bus.mem_tg_active[gi]),
         .test_complete  (bus.tg_test_complete[gi]),
         .test_failed    (bus.tg_test_failed[gi]),
         .timeout_cycles (bus.timeout_cycles),
         .pass           (pass_v[gi]),
         .fail           (fail_v[gi]),
         .timeout        (timeout_v[gi]),
         .clock_count    (cnt_v[gi])
      );
   end

   assign bus.tg_pass     = pass_v;
   assign bus.tg_fail     = fail_v;
   assign bus.tg_timeout  = timeout_v;
   assign bus.clock_count = cnt_v;

endmodule

// File: tb/tb_mem_tg2_run_monitor.sv
module tb_mem_tg2_run_monitor;
   localparam int NUM_TG = 4;
   localparam int TW     = 32;
   localparam longint unsigned CNT_MAX = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef MEM_TG2_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_tg2_run_monitor_if #(.NUM_TG(NUM_TG), .TIMEOUT_W(TW)) bus ();

   mem_tg2_run_monitor #(.NUM_TG(NUM_TG), .TIMEOUT_W(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: result code per channel (0 none, 1 pass, 2 fail, 3 timeout),
   // a running flag and the elapsed-clock count, updated from the spec rules.
   bit              m_run [NUM_TG];
   int              m_res [NUM_TG];
   longint unsigned m_cnt [NUM_TG];
   bit              m_pa  [NUM_TG];
   bit              m_pc  [NUM_TG];
   bit              m_pf  [NUM_TG];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_TG; c++) begin
            m_run[c] = 0; m_res[c] = 0; m_cnt[c] = 0;
            m_pa[c] = 0; m_pc[c] = 0; m_pf[c] = 0;
         end
      end else begin
         for (int c = 0; c < NUM_TG; c++) begin
            bit a, cm, fl;
            longint unsigned nc;
            longint unsigned t;
            a  = bus.mem_tg_active[c];
            cm = bus.tg_test_complete[c];
            fl = bus.tg_test_failed[c];
            t  = longint'(bus.timeout_cycles);
            if (a && !m_pa[c]) begin
               m_run[c] = 1; m_res[c] = 0; m_cnt[c] = 0;
            end else if (m_run[c]) begin
               nc = (m_cnt[c] == CNT_MAX) ? m_cnt[c] : m_cnt[c] + 1;
               if (fl && !m_pf[c]) m_res[c] = 2;
               else if (cm && !m_pc[c]) m_res[c] = fl ? 2 : 1;
               else if (WD_EN && t != 0 && m_cnt[c] + 1 == t) m_res[c] = 3;
               if (m_res[c] != 0) begin
                  m_run[c] = 0; m_cnt[c] = nc;
               end else if (!a) begin
                  m_run[c] = 0;
               end else begin
                  m_cnt[c] = nc;
               end
            end
            m_pa[c] = a; m_pc[c] = cm; m_pf[c] = fl;
         end
      end
   end

   task automatic clear_inputs();
      bus.mem_tg_active    = '0;
      bus.tg_test_complete = '0;
      bus.tg_test_failed   = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      bus.timeout_cycles = '0;
      repeat (3) @(negedge clk);
      for (int c = 0; c < NUM_TG; c++) begin
         n_checks++;
         if ({bus.tg_pass[c], bus.tg_fail[c], bus.tg_timeout[c]} !== 3'b000 || bus.clock_count[c] !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_hold ch%0d: status=%b count=%0d, expected 000 and 0", c,
                     {bus.tg_pass[c], bus.tg_fail[c], bus.tg_timeout[c]}, bus.clock_count[c]);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int c = 0; c < NUM_TG; c++) begin
         n_checks++;
         if ({bus.tg_pass[c], bus.tg_fail[c], bus.tg_timeout[c]} !== 3'b000 || bus.clock_count[c] !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_release ch%0d: status=%b count=%0d, expected 000 and 0", c,
                     {bus.tg_pass[c], bus.tg_fail[c], bus.tg_timeout[c]}, bus.clock_count[c]);
         end
      end
   endtask

   task automatic test_basic_pass();
      clear_inputs();
      @(negedge clk);
      bus.mem_tg_active[0] = 1'b1;
      repeat (100) @(negedge clk);
      n_checks++;
      if (bus.clock_count[0] !== 64'd99 || bus.tg_pass[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL pass_pre: count=%0d pass=%b, expected 99 and 0", bus.clock_count[0], bus.tg_pass[0]);
      end
      bus.tg_test_complete[0] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.tg_pass[0] !== 1'b1 || bus.tg_fail[0] !== 1'b0 || bus.clock_count[0] !== 64'd100) begin
         n_fail++;
         $display("FAIL pass_result: pass=%b fail=%b count=%0d, expected 1 0 100",
                  bus.tg_pass[0], bus.tg_fail[0], bus.clock_count[0]);
      end
      repeat (5) @(negedge clk);
      n_checks++;
      if (bus.tg_pass[0] !== 1'b1 || bus.clock_count[0] !== 64'd100) begin
         n_fail++;
         $display("FAIL pass_frozen: pass=%b count=%0d, expected 1 and 100", bus.tg_pass[0], bus.clock_count[0]);
      end
      clear_inputs();
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.tg_pass[0] !== 1'b1 || bus.clock_count[0] !== 64'd100) begin
         n_fail++;
         $display("FAIL pass_held_after_inactive: pass=%b count=%0d, expected 1 and 100",
                  bus.tg_pass[0], bus.clock_count[0]);
      end
   endtask

   task automatic test_fail_priority();
      clear_inputs();
      @(negedge clk);
      bus.mem_tg_active[2] = 1'b1;
      repeat (8) @(negedge clk);
      bus.tg_test_complete[2] = 1'b1;
      bus.tg_test_failed[2]   = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.tg_fail[2] !== 1'b1 || bus.tg_pass[2] !== 1'b0 || bus.clock_count[2] !== 64'd8) begin
         n_fail++;
         $display("FAIL fail_priority: fail=%b pass=%b count=%0d, expected 1 0 8",
                  bus.tg_fail[2], bus.tg_pass[2], bus.clock_count[2]);
      end
      // restart with failed held high: only a completion edge can end the run
      bus.mem_tg_active[2]    = 1'b0;
      bus.tg_test_complete[2] = 1'b0;
      @(negedge clk);
      bus.mem_tg_active[2] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.tg_fail[2] !== 1'b0 || bus.clock_count[2] !== 64'd0) begin
         n_fail++;
         $display("FAIL fail_restart: fail=%b count=%0d, expected 0 and 0", bus.tg_fail[2], bus.clock_count[2]);
      end
      repeat (3) @(negedge clk);
      bus.tg_test_complete[2] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.tg_fail[2] !== 1'b1 || bus.tg_pass[2] !== 1'b0 || bus.clock_count[2] !== 64'd4) begin
         n_fail++;
         $display("FAIL complete_with_failed_level: fail=%b pass=%b count=%0d, expected 1 0 4",
                  bus.tg_fail[2], bus.tg_pass[2], bus.clock_count[2]);
      end
   endtask

   task automatic test_watchdog();
      clear_inputs();
`ifdef MEM_TG2_WATCHDOG_EN
      bus.timeout_cycles = 32'd50;
      @(negedge clk);
      bus.mem_tg_active[1] = 1'b1;
      repeat (50) @(negedge clk);
      n_checks++;
      if (bus.tg_timeout[1] !== 1'b0 || bus.clock_count[1] !== 64'd49) begin
         n_fail++;
         $display("FAIL wd_pre: timeout=%b count=%0d, expected 0 and 49", bus.tg_timeout[1], bus.clock_count[1]);
      end
      @(negedge clk);
      n_checks++;
      if (bus.tg_timeout[1] !== 1'b1 || bus.clock_count[1] !== 64'd50) begin
         n_fail++;
         $display("FAIL wd_hit: timeout=%b count=%0d, expected 1 and 50", bus.tg_timeout[1], bus.clock_count[1]);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.tg_timeout[1] !== 1'b1 || bus.clock_count[1] !== 64'd50) begin
         n_fail++;
         $display("FAIL wd_frozen: timeout=%b count=%0d, expected 1 and 50", bus.tg_timeout[1], bus.clock_count[1]);
      end
      bus.timeout_cycles   = 32'd0;
      bus.mem_tg_active[1] = 1'b0;
      @(negedge clk);
      bus.mem_tg_active[1] = 1'b1;
      repeat (61) @(negedge clk);
      n_checks++;
      if (bus.tg_timeout[1] !== 1'b0 || bus.clock_count[1] !== 64'd60) begin
         n_fail++;
         $display("FAIL wd_disabled: timeout=%b count=%0d, expected 0 and 60", bus.tg_timeout[1], bus.clock_count[1]);
      end
      @(negedge clk);
      n_checks++;
      if (bus.clock_count[1] !== 64'd61) begin
         n_fail++;
         $display("FAIL wd_disabled_running: count=%0d, expected 61", bus.clock_count[1]);
      end
`else
      bus.timeout_cycles = 32'd5;
      @(negedge clk);
      bus.mem_tg_active[1] = 1'b1;
      repeat (101) @(negedge clk);
      n_checks++;
      if (bus.tg_timeout[1] !== 1'b0 || bus.clock_count[1] !== 64'd100) begin
         n_fail++;
         $display("FAIL no_wd: timeout=%b count=%0d, expected 0 and 100", bus.tg_timeout[1], bus.clock_count[1]);
      end
`endif
      bus.timeout_cycles = 32'd0;
   endtask

   task automatic test_restart_stale();
      clear_inputs();
      @(negedge clk);
      bus.mem_tg_active[3] = 1'b1;
      repeat (6) @(negedge clk);
      bus.tg_test_complete[3] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.tg_pass[3] !== 1'b1 || bus.clock_count[3] !== 64'd6) begin
         n_fail++;
         $display("FAIL stale_first_pass: pass=%b count=%0d, expected 1 and 6", bus.tg_pass[3], bus.clock_count[3]);
      end
      bus.mem_tg_active[3] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.tg_pass[3] !== 1'b1) begin
         n_fail++;
         $display("FAIL stale_pass_held: pass=%b, expected 1", bus.tg_pass[3]);
      end
      bus.mem_tg_active[3] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.tg_pass[3] !== 1'b0 || bus.clock_count[3] !== 64'd0) begin
         n_fail++;
         $display("FAIL restart_clear: pass=%b count=%0d, expected 0 and 0", bus.tg_pass[3], bus.clock_count[3]);
      end
      repeat (10) @(negedge clk);
      n_checks++;
      if (bus.tg_pass[3] !== 1'b0 || bus.clock_count[3] !== 64'd10) begin
         n_fail++;
         $display("FAIL stale_ignored: pass=%b count=%0d, expected 0 and 10", bus.tg_pass[3], bus.clock_count[3]);
      end
      bus.tg_test_complete[3] = 1'b0;
      @(negedge clk);
      bus.tg_test_complete[3] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.tg_pass[3] !== 1'b1 || bus.clock_count[3] !== 64'd12) begin
         n_fail++;
         $display("FAIL fresh_edge_pass: pass=%b count=%0d, expected 1 and 12", bus.tg_pass[3], bus.clock_count[3]);
      end
   endtask

   task automatic test_abort_reset();
      clear_inputs();
      @(negedge clk);
      bus.mem_tg_active[0] = 1'b1;
      repeat (21) @(negedge clk);
      n_checks++;
      if (bus.clock_count[0] !== 64'd20) begin
         n_fail++;
         $display("FAIL abort_pre: count=%0d, expected 20", bus.clock_count[0]);
      end
      bus.mem_tg_active[0] = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if ({bus.tg_pass[0], bus.tg_fail[0], bus.tg_timeout[0]} !== 3'b000 || bus.clock_count[0] !== 64'd20) begin
         n_fail++;
         $display("FAIL abort: status=%b count=%0d, expected 000 and 20",
                  {bus.tg_pass[0], bus.tg_fail[0], bus.tg_timeout[0]}, bus.clock_count[0]);
      end
      bus.mem_tg_active[0] = 1'b1;
      bus.mem_tg_active[1] = 1'b1;
      repeat (10) @(negedge clk);
      bus.tg_test_complete[0] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.tg_pass[0] !== 1'b1 || bus.clock_count[1] !== 64'd10) begin
         n_fail++;
         $display("FAIL pre_reset: pass0=%b count1=%0d, expected 1 and 10", bus.tg_pass[0], bus.clock_count[1]);
      end
      rst_n = 1'b0;
      #1;
      for (int c = 0; c < NUM_TG; c++) begin
         n_checks++;
         if ({bus.tg_pass[c], bus.tg_fail[c], bus.tg_timeout[c]} !== 3'b000 || bus.clock_count[c] !== 64'd0) begin
            n_fail++;
            $display("FAIL midrun_reset ch%0d: status=%b count=%0d, expected 000 and 0", c,
                     {bus.tg_pass[c], bus.tg_fail[c], bus.tg_timeout[c]}, bus.clock_count[c]);
         end
      end
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.tg_pass !== 4'b0 || bus.clock_count[0] !== 64'd0 || bus.clock_count[1] !== 64'd0) begin
         n_fail++;
         $display("FAIL post_reset: pass=%b count0=%0d count1=%0d, expected 0", bus.tg_pass,
                  bus.clock_count[0], bus.clock_count[1]);
      end
   endtask

   task automatic test_random();
      int unsigned tsel [4] = '{0, 7, 25, 60};
      int printed = 0;
      clear_inputs();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         for (int c = 0; c < NUM_TG; c++) begin
            n_checks++;
            if (bus.tg_pass[c] !== (m_res[c] == 1) || bus.tg_fail[c] !== (m_res[c] == 2) ||
                bus.tg_timeout[c] !== (m_res[c] == 3) || bus.clock_count[c] !== m_cnt[c]) begin
               n_fail++;
               if (printed < 20) begin
                  printed++;
                  $display("FAIL random cyc%0d ch%0d: pft=%b count=%0d, expected result %0d count %0d", cyc, c,
                           {bus.tg_pass[c], bus.tg_fail[c], bus.tg_timeout[c]}, bus.clock_count[c],
                           m_res[c], m_cnt[c]);
               end
            end
         end
         if (cyc % 500 == 0) bus.timeout_cycles = tsel[$urandom_range(3)];
         for (int c = 0; c < NUM_TG; c++) begin
            if ($urandom_range(39) == 0) bus.mem_tg_active[c] = ~bus.mem_tg_active[c];
            if ($urandom_range(14) == 0) bus.tg_test_complete[c] = ~bus.tg_test_complete[c];
            if ($urandom_range(24) == 0) bus.tg_test_failed[c] = ~bus.tg_test_failed[c];
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_pass();
      test_fail_priority();
      test_watchdog();
      test_restart_stale();
      test_abort_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
